bitu_grp_iter: RTL

Parametrised, iterative successor to the combinational group (GRP) bit-manipulation unit in the pipeline's bit-manipulation path. It computes GRP, GRPR and GRPL, and optionally UNGRP, for XLEN 32 or 64. Each operation takes log2(XLEN) merge levels, one level per clock, in place of a deep combinational butterfly network. A valid/ready request/response handshake with a tag lets the execute stage issue operations and retire them out of the critical path.

---
 rtl/bitu_pkg.sv | 22 ++
 rtl/bitu_merge_level.sv | 55 +++++
 rtl/bitu_grp_iter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitu_pkg.sv
// Shared types and helpers for the iterative group/ungroup bit-manipulation unit.
package bitu_pkg;

    typedef enum logic [1:0] {
        BITU_GRP   = 2'b00,
        BITU_GRPR  = 2'b01,
        BITU_GRPL  = 2'b10,
        BITU_UNGRP = 2'b11
    } bitu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bitu_state_e;

    // Number of merge levels for a given datapath width.
    function automatic int bitu_levels(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/bitu_merge_level.sv
// One merge level of one lane: compress pairs of 2^lvl-bit blocks toward the LSB,
// or (when DEPOSIT_EN) split each 2^(lvl+1)-bit block back into its two halves.
module bitu_merge_level
    import bitu_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter bit  DEPOSIT_EN = 1'b0,
    localparam int L          = bitu_levels(XLEN),
    localparam int CW         = L + 1,
    localparam int LW         = $clog2(L)
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [CW-1:0]   cnt_i [XLEN],
    input  logic [LW-1:0]   lvl_i,
    input  logic            deposit_i,
    output logic [XLEN-1:0] data_o,
    output logic [CW-1:0]   cnt_o [XLEN]
);

    localparam logic [XLEN-1:0] ONES = '1;

    // Block counts live at the first bit index of each block; packed bits sit at the block bottom.
    always_comb begin
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] blk;
        logic [XLEN-1:0] merged;
        lo     = '0;
        hi     = '0;
        blk    = '0;
        merged = '0;
        data_o = data_i;
        cnt_o  = cnt_i;
        for (int l = 0; l < L; l++) begin
            if (lvl_i == LW'(l)) begin
                data_o = '0;
                for (int p = 0; p < XLEN; p += (2 << l)) begin
                    if (DEPOSIT_EN && deposit_i) begin
                        blk    = (data_i >> p) & ~(ONES << (2 << l));
                        lo     = blk & ~(ONES << cnt_i[p]);
                        hi     = (blk >> cnt_i[p]) & ~(ONES << (1 << l));
                        merged = lo | (hi << (1 << l));
                    end else begin
                        lo       = (data_i >> p) & ~(ONES << (1 << l));
                        hi       = (data_i >> (p + (1 << l))) & ~(ONES << (1 << l));
                        merged   = lo | (hi << cnt_i[p]);
                        cnt_o[p] = cnt_i[p] + cnt_i[p + (1 << l)];
                    end
                    data_o = data_o | (merged << p);
                end
            end
        end
    end

endmodule

// File: rtl/bitu_grp_iter.sv
// Iterative GRP/GRPR/GRPL unit, one merge level per clock, with valid/ready and tag.
// Define BITU_UNGRP_EN to make op 11 perform UNGRP; otherwise op 11 returns the operand.
module bitu_grp_iter
    import bitu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_data_i,
    input  logic [XLEN-1:0]  req_mask_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o
);

    localparam int L  = bitu_levels(XLEN);
    localparam int CW = L + 1;
    localparam int LW = $clog2(L);

    function automatic logic [XLEN-1:0] mirror(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
        return r;
    endfunction

    bitu_state_e     state_q, state_d;
    logic [LW-1:0]   lvl_q, lvl_d, lvl_eff;
    bitu_op_e        op_q;
    logic [TAG_W-1:0] tag_q, rsp_tag_q;
    logic [XLEN-1:0] rdat_q, ldat_q, rdat_ld, ldat_ld, rdat_m, ldat_m;
    logic [XLEN-1:0] rsp_data_q, result;
    logic [CW-1:0]   rcnt_q [XLEN];
    logic [CW-1:0]   lcnt_q [XLEN];
    logic [CW-1:0]   rcnt_ld [XLEN];
    logic [CW-1:0]   lcnt_ld [XLEN];
    logic [CW-1:0]   rcnt_in [XLEN];
    logic [CW-1:0]   lcnt_in [XLEN];
    logic [CW-1:0]   rcnt_m [XLEN];
    logic [CW-1:0]   lcnt_m [XLEN];
    logic            accept, last_lvl, deposit;

    assign req_ready_o = !rst_i && !flush_i &&
                         ((state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign last_lvl    = (lvl_q == LW'(L - 1));
    assign rsp_valid_o = (state_q == ST_DONE);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;

`ifdef BITU_UNGRP_EN
    localparam bit DEP_EN = 1'b1;
    localparam logic [XLEN-1:0] ONES = '1;

    logic [CW-1:0] rtab_d [L+1][XLEN];
    logic [CW-1:0] ltab_d [L+1][XLEN];
    logic [CW-1:0] rtab_q [L][XLEN];
    logic [CW-1:0] ltab_q [L][XLEN];
    logic [CW-1:0] pcnt;
    logic [XLEN-1:0] lmask_pre;

    // Block-count tree of both lane masks, so deposit can walk the levels top-down.
    always_comb begin
        lmask_pre = mirror(~req_mask_i);
        for (int l = 0; l <= L; l++) begin
            for (int i = 0; i < XLEN; i++) begin
                rtab_d[l][i] = '0;
                ltab_d[l][i] = '0;
            end
        end
        for (int i = 0; i < XLEN; i++) begin
            rtab_d[0][i] = CW'(req_mask_i[i]);
            ltab_d[0][i] = CW'(lmask_pre[i]);
        end
        for (int l = 1; l <= L; l++) begin
            for (int i = 0; i < XLEN; i += (1 << l)) begin
                rtab_d[l][i] = rtab_d[l-1][i] + rtab_d[l-1][i + (1 << (l - 1))];
                ltab_d[l][i] = ltab_d[l-1][i] + ltab_d[l-1][i + (1 << (l - 1))];
            end
        end
    end

    assign pcnt    = rtab_d[L][0];
    assign deposit = (op_q == BITU_UNGRP);
    assign lvl_eff = deposit ? (LW'(L - 1) - lvl_q) : lvl_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int l = 0; l < L; l++) begin
                for (int i = 0; i < XLEN; i++) begin
                    rtab_q[l][i] <= rtab_d[l][i];
                    ltab_q[l][i] <= ltab_d[l][i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < XLEN; i++) begin
            rcnt_in[i] = deposit ? rtab_q[lvl_eff][i] : rcnt_q[i];
            lcnt_in[i] = deposit ? ltab_q[lvl_eff][i] : lcnt_q[i];
        end
    end
`else
    localparam bit DEP_EN = 1'b0;

    assign deposit = 1'b0;
    assign lvl_eff = lvl_q;

    always_comb begin
        rcnt_in = rcnt_q;
        lcnt_in = lcnt_q;
    end
`endif

    // Lane seeds: the left lane works on the mirrored ~mask bits so it can reuse LSB packing.
    always_comb begin
        logic [XLEN-1:0] lmask;
        lmask   = mirror(~req_mask_i);
        rdat_ld = req_data_i & req_mask_i;
        ldat_ld = mirror(req_data_i) & lmask;
        for (int i = 0; i < XLEN; i++) begin
            rcnt_ld[i] = CW'(req_mask_i[i]);
            lcnt_ld[i] = CW'(lmask[i]);
        end
`ifdef BITU_UNGRP_EN
        if (bitu_op_e'(req_op_i) == BITU_UNGRP) begin
            rdat_ld = req_data_i & ~(ONES << pcnt);
            ldat_ld = mirror(req_data_i) & ~(ONES << (CW'(XLEN) - pcnt));
        end
`else
        if (bitu_op_e'(req_op_i) == BITU_UNGRP) begin
            rdat_ld = req_data_i;
            ldat_ld = '0;
            for (int i = 0; i < XLEN; i++) begin
                rcnt_ld[i] = CW'(1);
                lcnt_ld[i] = '0;
            end
        end
`endif
    end

    bitu_merge_level #(.XLEN(XLEN), .DEPOSIT_EN(DEP_EN)) u_merge_r (
        .data_i    (rdat_q),
        .cnt_i     (rcnt_in),
        .lvl_i     (lvl_eff),
        .deposit_i (deposit),
        .data_o    (rdat_m),
        .cnt_o     (rcnt_m)
    );

    bitu_merge_level #(.XLEN(XLEN), .DEPOSIT_EN(DEP_EN)) u_merge_l (
        .data_i    (ldat_q),
        .cnt_i     (lcnt_in),
        .lvl_i     (lvl_eff),
        .deposit_i (deposit),
        .data_o    (ldat_m),
        .cnt_o     (lcnt_m)
    );

    always_comb begin
        result = rdat_m | mirror(ldat_m);
        case (op_q)
            BITU_GRPR: result = rdat_m;
            BITU_GRPL: result = mirror(ldat_m);
            default:   result = rdat_m | mirror(ldat_m);
        endcase
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    lvl_d   = '0;
                end
            end
            ST_RUN: begin
                if (last_lvl) begin
                    state_d = ST_DONE;
                    lvl_d   = '0;
                end else begin
                    lvl_d = lvl_q + LW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) state_d = accept ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            lvl_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lvl_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            if ((state_q == ST_RUN) && last_lvl) begin
                rsp_data_q <= result;
                rsp_tag_q  <= tag_q;
            end
        end
    end

    // Datapath needs no reset: it is always seeded on accept before being observed.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q   <= bitu_op_e'(req_op_i);
            tag_q  <= req_tag_i;
            rdat_q <= rdat_ld;
            ldat_q <= ldat_ld;
            rcnt_q <= rcnt_ld;
            lcnt_q <= lcnt_ld;
        end else if (state_q == ST_RUN) begin
            rdat_q <= rdat_m;
            ldat_q <= ldat_m;
            rcnt_q <= rcnt_m;
            lcnt_q <= lcnt_m;
        end
    end

endmodule
